// File: rtl/crc8_frame_checker_pkg.sv
// -----------------------------------------------------------------------------
// crc8_frame_checker_pkg
//
// Shared constants and types for the receive-side CRC8/Maxim frame checker.
//
// CRC8/Maxim (a.k.a. Dallas/1-Wire): polynomial 0x31, processed reflected
// (LSB first, so the shift register uses the bit-reversed polynomial 0x8C),
// init 0x00, no final xor. Running the CRC over payload followed by the
// appended check byte leaves a residue of 0x00 for an intact frame.
// -----------------------------------------------------------------------------
package crc8_frame_checker_pkg;

    // Width of one stream byte.
    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    // Reflected form of the 0x31 generator polynomial.
    localparam byte_t CRC8_MAXIM_POLY_REFL = 8'h8C;

    // Register value at the start of every frame.
    localparam byte_t CRC8_MAXIM_INIT = 8'h00;

    // Register value after payload + appended CRC byte of a good frame.
    localparam byte_t CRC8_MAXIM_RESIDUE = 8'h00;

endpackage : crc8_frame_checker_pkg

// File: rtl/crc8_maxim.sv
// -----------------------------------------------------------------------------
// crc8_maxim
//
// Purely combinational single-byte CRC8/Maxim update step.
//
// Ports:
//   last_crc  in   8  current CRC register value
//   data      in   8  byte to fold into the CRC
//   crc       out  8  CRC register value after consuming data
// -----------------------------------------------------------------------------
module crc8_maxim
    import crc8_frame_checker_pkg::*;
(
    input  logic [BYTE_W-1:0] last_crc,
    input  logic [BYTE_W-1:0] data,
    output logic [BYTE_W-1:0] crc
);

    byte_t work;

    always_comb begin
        // NOTE: every variable written here is assigned unconditionally first,
        // so no path leaves it holding an old value and no latch is inferred.
        work = last_crc ^ data;
        // Reflected algorithm: shift right, fold in the reversed polynomial
        // whenever the bit falling off the bottom is set.
        for (int i = 0; i < BYTE_W; i++) begin
            if (work[0]) begin
                work = (work >> 1) ^ CRC8_MAXIM_POLY_REFL;
            end else begin
                work = work >> 1;
            end
        end
        crc = work;
    end

endmodule : crc8_maxim

// File: rtl/crc8_frame_checker.sv
// -----------------------------------------------------------------------------
// crc8_frame_checker
//
// Receive-side frame checker. The last byte of every input frame is the
// CRC8/Maxim check byte appended by the transmitter. Payload bytes are
// forwarded downstream with the CRC byte stripped and out_last on the real
// last payload byte; per-frame status is pulsed one cycle after the CRC byte
// is accepted.
//
// Ports:
//   clk         in   1      single clock
//   rst         in   1      synchronous, active-high reset
//   in_data     in   8      incoming byte
//   in_valid    in   1      in_data is valid
//   in_last     in   1      current byte is the frame's CRC byte
//   in_ready    out  1      checker accepts a byte this cycle
//   out_data    out  8      payload byte
//   out_valid   out  1      out_data is valid
//   out_last    out  1      last payload byte of the frame
//   out_ready   in   1      downstream accepts the byte
//   frame_done  out  1      pulse: a frame's CRC byte was accepted
//   crc_ok      out  1      CRC status, qualified by frame_done
//   runt_err    out  1      pulse: frame held only a CRC byte
//   frame_len   out  LEN_W  payload byte count, qualified by frame_done
//
// Datapath: a byte is parked in the hold register until the next byte shows
// whether it was payload (next byte is data or CRC) -- only then does it move
// to the output register. This gives a 2-cycle input-to-output latency at one
// byte per cycle.
// -----------------------------------------------------------------------------
module crc8_frame_checker
    import crc8_frame_checker_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,

    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,

    output logic              frame_done,
    output logic              crc_ok,
    output logic              runt_err,
    output logic [LEN_W-1:0]  frame_len
);

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    // Hold register: byte not yet known to be payload.
    byte_t             hold_data;
    logic              hold_valid;

    // Running CRC and payload length of the frame in progress.
    byte_t             crc_q;
    byte_t             crc_next;
    logic [LEN_W-1:0]  count;

    logic              accept;
    logic              accept_data;
    logic              accept_last;
    logic              drain;
    logic              load_out;

    // -------------------------------------------------------------------------
    // Handshakes
    // -------------------------------------------------------------------------
    // Accepting a byte may push the held byte into the output register, so
    // input is only allowed when that register is empty or draining now.
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign accept_data = accept && !in_last;
    assign accept_last = accept && in_last;
    assign drain       = out_valid && out_ready;
    // Any accepted byte (data or CRC) proves the held byte was payload.
    assign load_out    = accept && hold_valid;

    crc8_maxim u_crc8_maxim (
        .last_crc (crc_q),
        .data     (in_data),
        .crc      (crc_next)
    );

    // -------------------------------------------------------------------------
    // Hold register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: only hold_valid is reset; hold_data is always qualified by
            // hold_valid, so leaving the data bits out of reset costs nothing.
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            hold_valid <= 1'b0;
        end else if (accept_data) begin
            hold_valid <= 1'b1;
        end else if (accept_last) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept_data) begin
            hold_data <= in_data;
        end
    end

    // -------------------------------------------------------------------------
    // Running CRC and saturating payload counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q <= CRC8_MAXIM_INIT;
            count <= '0;
        end else if (accept_data) begin
            crc_q <= crc_next;
            if (count != LEN_MAX) begin
                count <= count + 1'b1;
            end
        end else if (accept_last) begin
            // The CRC byte closes the frame; the next byte starts a fresh one.
            crc_q <= CRC8_MAXIM_INIT;
            count <= '0;
        end
    end

    // -------------------------------------------------------------------------
    // Output register
    // -------------------------------------------------------------------------
    // out_data/out_last change only on a load, and a load only happens when the
    // register is empty or draining, so they stay stable through a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load_out) begin
            out_data  <= hold_data;
            out_last  <= in_last;
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Frame status (registered, one cycle after the CRC byte is accepted)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_done <= 1'b0;
            runt_err   <= 1'b0;
            crc_ok     <= 1'b0;
            frame_len  <= '0;
        end else begin
            frame_done <= accept_last;
            // No held byte at the CRC byte means the frame had no payload.
            runt_err   <= accept_last && !hold_valid;
            if (accept_last) begin
                crc_ok    <= hold_valid && (crc_next == CRC8_MAXIM_RESIDUE);
                frame_len <= hold_valid ? count : '0;
            end
        end
    end

endmodule : crc8_frame_checker

// File: tb/tb_crc8_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_crc8_frame_checker
//
// Table of frames with their known-good expected status is streamed through
// the checker. Payload bytes are pushed to a scoreboard queue as they are
// accepted and popped as the DUT emits them; expected status is queued per
// frame and popped on frame_done. Hand-written sequences cover reset and a
// mid-frame reset.
// -----------------------------------------------------------------------------
module tb_crc8_frame_checker;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 200;
    localparam int NVEC    = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_last;
    logic             out_ready;
    logic             frame_done;
    logic             crc_ok;
    logic             runt_err;
    logic [LEN_W-1:0] frame_len;

    crc8_frame_checker #(.LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .runt_err   (runt_err),
        .frame_len  (frame_len)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } payload_t;

    typedef struct packed {
        logic        ok;
        logic        runt;
        logic [15:0] len;
    } status_t;

    typedef struct {
        logic [7:0] bytes [10];
        int         n;
        logic       exp_ok;
        int         exp_len;
        logic       exp_runt;
        logic       stall;
    } frame_vec_t;

    payload_t   exp_q [$];
    status_t    stat_q [$];
    frame_vec_t vec [NVEC];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic       stall_mode = 1'b0;
    logic       ready_pat [8];
    int         phase = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Downstream ready: always 1, or a 1010 toggle followed by a 3-cycle stall.
    always begin
        @(posedge clk);
        #1;
        if (!stall_mode) begin
            out_ready = 1'b1;
        end else begin
            out_ready = ready_pat[phase % 8];
            phase++;
        end
    end

    // Monitor: sampled on the falling edge, away from the active edge.
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (!out_valid || out_ready)});
            if (prev_stall) begin
                check("stall_valid", {31'd0, out_valid}, 32'd1);
                check("stall_data", {24'd0, out_data}, {24'd0, prev_data});
                check("stall_last", {31'd0, out_last}, {31'd0, prev_last});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out: got %0h expected no output", out_data);
                end else begin
                    payload_t e;
                    e = exp_q.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, e.data});
                    check("out_last", {31'd0, out_last}, {31'd0, e.last});
                end
            end
            if (frame_done) begin
                if (stat_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got frame_done expected none");
                end else begin
                    status_t s;
                    s = stat_q.pop_front();
                    check("crc_ok", {31'd0, crc_ok}, {31'd0, s.ok});
                    check("frame_len", {16'd0, frame_len}, {16'd0, s.len});
                    check("runt_err", {31'd0, runt_err}, {31'd0, s.runt});
                end
            end else begin
                check("runt_without_done", {31'd0, runt_err}, 32'd0);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic send_byte(input logic [7:0] d, input logic l, input logic exp_last);
        int waited = 0;
        bit done   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                if (!l) exp_q.push_back('{last: exp_last, data: d});
            end
            @(posedge clk);
            #1;
            waited++;
            if (!done && waited > TIMEOUT) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: got no in_ready expected accept within %0d cycles", TIMEOUT);
                done = 1;
            end
        end
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input frame_vec_t v);
        int start;
        stall_mode = v.stall;
        stat_q.push_back('{ok: v.exp_ok, runt: v.exp_runt, len: 16'(v.exp_len)});
        start = cyc;
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.bytes[i], (i == v.n - 1), (i == v.n - 2));
        end
        if (!v.stall) check("input_cycles", 32'(cyc - start), 32'(v.n));
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        check("rst_frame_done", {31'd0, frame_done}, 32'd0);
        check("rst_runt_err", {31'd0, runt_err}, 32'd0);
        check("rst_crc_ok", {31'd0, crc_ok}, 32'd0);
        check("rst_frame_len", {16'd0, frame_len}, 32'd0);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        ready_pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

        vec[0] = '{bytes: '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hA1},
                   n: 10, exp_ok: 1'b1, exp_len: 9, exp_runt: 1'b0, stall: 1'b0};
        vec[1] = '{bytes: '{8'h01, 8'h5E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   n: 2, exp_ok: 1'b1, exp_len: 1, exp_runt: 1'b0, stall: 1'b0};
        vec[2] = '{bytes: '{8'h01, 8'h5F, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   n: 2, exp_ok: 1'b0, exp_len: 1, exp_runt: 1'b0, stall: 1'b0};
        vec[3] = '{bytes: '{8'hA1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   n: 1, exp_ok: 1'b0, exp_len: 0, exp_runt: 1'b1, stall: 1'b0};
        vec[4] = '{bytes: '{8'h01, 8'h5E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   n: 2, exp_ok: 1'b1, exp_len: 1, exp_runt: 1'b0, stall: 1'b0};
        vec[5] = '{bytes: '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hA1},
                   n: 10, exp_ok: 1'b1, exp_len: 9, exp_runt: 1'b0, stall: 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Back-to-back frames from the table, including the runt frame.
        for (int i = 0; i < NVEC; i++) begin
            run_frame(vec[i]);
        end
        stall_mode = 1'b0;
        idle(6);
        check("drained_payload", 32'(exp_q.size()), 32'd0);
        check("drained_status", 32'(stat_q.size()), 32'd0);

        // Reset in the middle of a frame: 4 payload bytes, then abort.
        send_byte(8'h31, 1'b0, 1'b0);
        send_byte(8'h32, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b0);
        send_byte(8'h34, 1'b0, 1'b0);
        rst = 1'b1;
        exp_q.delete();
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        check_reset_state();
        @(posedge clk);
        #1;

        // Following frame must see no leftover CRC or count.
        run_frame(vec[1]);
        idle(6);
        check("final_payload", 32'(exp_q.size()), 32'd0);
        check("final_status", 32'(stat_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_crc8_frame_checker
